// File: rtl/obstacles_sequencer_pkg.sv
// Shared types for the obstacle sequencer: FSM states, one-hot obstacle codes,
// screen coordinate width and the order-rotation helper.
package obstacles_sequencer_pkg;
  localparam int COORD_W = 12;
  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_START, S_WAIT_WORK, S_RUN, S_GAP, S_OVER
  } seq_state_t;

  localparam logic [3:0] OBS_NONE = 4'b0000;
  localparam logic [3:0] OBS_0    = 4'b0001;
  localparam logic [3:0] OBS_1    = 4'b0010;
  localparam logic [3:0] OBS_2    = 4'b0100;
  localparam logic [3:0] OBS_3    = 4'b1000;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  function automatic logic [3:0] rotl_code(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction
endpackage

// File: rtl/obstacles_sequencer_if.sv
// Game-mode, obstacle handshake and status signals of the obstacle sequencer.
interface obstacles_sequencer_if;
  import obstacles_sequencer_pkg::*;

  logic       game_on, menu_on, play_selected;
  logic       working_in, done_in;
  coord_t     obstacle_x_in, obstacle_y_in, player_x, player_y;
  logic [3:0] selected;
  logic       done_control, player_hit, game_over;
  logic [2:0] lives;

  modport master (
    output game_on, menu_on, play_selected, working_in, done_in,
           obstacle_x_in, obstacle_y_in, player_x, player_y,
    input  selected, done_control, player_hit, lives, game_over
  );

  modport slave (
    input  game_on, menu_on, play_selected, working_in, done_in,
           obstacle_x_in, obstacle_y_in, player_x, player_y,
    output selected, done_control, player_hit, lives, game_over
  );
endinterface

// File: rtl/obstacles_collision_check.sv
// Player box vs. drawn obstacle pixel compare; hit flag registered (1-cycle latency).
module obstacles_collision_check
  import obstacles_sequencer_pkg::*;
#(
  parameter int PLAYER_SIZE = 20
) (
  input  logic   pclk,
  input  logic   rst,
  input  coord_t obstacle_x,
  input  coord_t obstacle_y,
  input  coord_t player_x,
  input  coord_t player_y,
  output logic   hit
);
  localparam int SUM_W = COORD_W + 1;

  // One extra bit so a player near the right/bottom edge never wraps to a small bound.
  logic [SUM_W-1:0] x_hi, y_hi;
  logic             present, in_x, in_y;

  assign x_hi    = {1'b0, player_x} + SUM_W'(PLAYER_SIZE - 1);
  assign y_hi    = {1'b0, player_y} + SUM_W'(PLAYER_SIZE - 1);
  assign present = (obstacle_x != '0) || (obstacle_y != '0);
  assign in_x    = (obstacle_x >= player_x) && ({1'b0, obstacle_x} <= x_hi);
  assign in_y    = (obstacle_y >= player_y) && ({1'b0, obstacle_y} <= y_hi);

  always_ff @(posedge pclk) begin
    if (rst) hit <= 1'b0;
    else     hit <= present && in_x && in_y;
  end
endmodule

// File: rtl/obstacles_sequencer.sv
// Obstacle sequencer: picks the next obstacle, starts it, tracks hits/lives/game over.
// Define OBSTACLES_RANDOM_ORDER_EN for LFSR-driven order instead of round-robin.
module obstacles_sequencer
  import obstacles_sequencer_pkg::*;
#(
  parameter int LIVES_INIT    = 3,
  parameter int GAP_CYCLES    = 32000000,
  parameter int HIT_COOLDOWN  = 65000000,
  parameter int PLAYER_SIZE   = 20,
  parameter int START_TIMEOUT = 16
) (
  input logic                  pclk,
  input logic                  rst,
  obstacles_sequencer_if.slave bus
);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int CD_W  = $clog2(HIT_COOLDOWN + 1);
  localparam int TO_W  = $clog2(START_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(START_TIMEOUT - 1);

  seq_state_t       state, state_n;
  logic [3:0]       selected, sel_n, rr_ptr, ptr_n, next_code, next_ptr;
  logic             done_control, dc_n, player_hit, hit_n, game_over, over_n;
  logic [2:0]       lives, lives_n;
  logic [GAP_W-1:0] gap_cnt, gap_n;
  logic [TO_W-1:0]  to_cnt, to_n;
  logic [CD_W-1:0]  cooldown, cd_n;
  logic             hit_q, working_q, count_hit, abort;

  obstacles_collision_check #(.PLAYER_SIZE(PLAYER_SIZE)) u_coll (
    .pclk       (pclk),
    .rst        (rst),
    .obstacle_x (bus.obstacle_x_in),
    .obstacle_y (bus.obstacle_y_in),
    .player_x   (bus.player_x),
    .player_y   (bus.player_y),
    .hit        (hit_q)
  );

`ifdef OBSTACLES_RANDOM_ORDER_EN
  logic [7:0] lfsr;
  logic [3:0] rand_code;

  always_ff @(posedge pclk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // rr_ptr holds the previously issued code; never repeat it back-to-back.
  assign rand_code = 4'b0001 << lfsr[1:0];
  assign next_code = (rand_code == rr_ptr) ? rotl_code(rand_code) : rand_code;
  assign next_ptr  = next_code;
`else
  assign next_code = rr_ptr;
  assign next_ptr  = rotl_code(rr_ptr);
`endif

  always_ff @(posedge pclk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    sel_n     = selected;
    ptr_n     = rr_ptr;
    dc_n      = 1'b0;
    hit_n     = 1'b0;
    lives_n   = lives;
    over_n    = game_over;
    gap_n     = gap_cnt;
    to_n      = to_cnt;
    cd_n      = (cooldown != '0) ? cooldown - CD_W'(1) : '0;
    count_hit = (state == S_RUN) && hit_q && (cooldown == '0);
    abort     = (bus.menu_on || !bus.play_selected) && (state != S_OVER);

    case (state)
      S_IDLE: begin
        sel_n = OBS_NONE;
        if (bus.game_on && bus.play_selected && !bus.menu_on) begin
          lives_n = 3'(LIVES_INIT);
          state_n = S_SELECT;
        end
      end
      S_SELECT: begin
        sel_n   = next_code;
        ptr_n   = next_ptr;
        state_n = S_START;
      end
      // selected became visible on entry here; the start pulse follows one cycle later.
      S_START: begin
        dc_n    = 1'b1;
        to_n    = '0;
        state_n = S_WAIT_WORK;
      end
      S_WAIT_WORK: begin
        if (bus.working_in) state_n = S_RUN;
        else if (to_cnt == TO_LAST) begin
          state_n = S_GAP;
          gap_n   = '0;
        end else to_n = to_cnt + TO_W'(1);
      end
      S_RUN: begin
        if (bus.done_in || (working_q && !bus.working_in)) begin
          state_n = S_GAP;
          gap_n   = '0;
        end
        if (count_hit) begin
          hit_n   = 1'b1;
          lives_n = lives - 3'd1;
          cd_n    = CD_W'(HIT_COOLDOWN);
          if (lives == 3'd1) begin
            state_n = S_OVER;
            sel_n   = OBS_NONE;
            over_n  = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_n = S_SELECT;
        else gap_n = gap_cnt + GAP_W'(1);
      end
      S_OVER: begin
        sel_n  = OBS_NONE;
        over_n = 1'b1;
        if (bus.menu_on) begin
          state_n = S_IDLE;
          over_n  = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Leaving play drops everything except the life count.
    if (abort) begin
      state_n = S_IDLE;
      sel_n   = OBS_NONE;
      dc_n    = 1'b0;
      hit_n   = 1'b0;
      lives_n = lives;
      gap_n   = '0;
      to_n    = '0;
      cd_n    = '0;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      selected     <= OBS_NONE;
      rr_ptr       <= OBS_0;
      done_control <= 1'b0;
      player_hit   <= 1'b0;
      lives        <= '0;
      game_over    <= 1'b0;
      gap_cnt      <= '0;
      to_cnt       <= '0;
      cooldown     <= '0;
      working_q    <= 1'b0;
    end else begin
      selected     <= sel_n;
      rr_ptr       <= ptr_n;
      done_control <= dc_n;
      player_hit   <= hit_n;
      lives        <= lives_n;
      game_over    <= over_n;
      gap_cnt      <= gap_n;
      to_cnt       <= to_n;
      cooldown     <= cd_n;
      working_q    <= bus.working_in;
    end
  end

  assign bus.selected     = selected;
  assign bus.done_control = done_control;
  assign bus.player_hit   = player_hit;
  assign bus.lives        = lives;
  assign bus.game_over    = game_over;
endmodule

// File: tb/tb_obstacles_sequencer.sv
// Self-checking bench for obstacles_sequencer: collision table, directed game
// sequences, and randomized hit/cooldown play against a reference model.
module tb_obstacles_sequencer;
  import obstacles_sequencer_pkg::*;

  localparam int LIVES = 3;
  localparam int GAP   = 40;
  localparam int HC    = 150;
  localparam int TO    = 16;
  localparam int PS    = 20;
`ifdef OBSTACLES_RANDOM_ORDER_EN
  localparam int NSEL  = 50;
`else
  localparam int NSEL  = 5;
`endif

  typedef struct {
    int px; int py; int ox; int oy; bit hit;
  } cvec_t;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  obstacles_sequencer_if bus();

  obstacles_sequencer #(
    .LIVES_INIT(LIVES), .GAP_CYCLES(GAP), .HIT_COOLDOWN(HC),
    .PLAYER_SIZE(PS), .START_TIMEOUT(TO)
  ) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  coord_t cc_px, cc_py, cc_ox, cc_oy;
  logic   cc_hit;
  obstacles_collision_check #(.PLAYER_SIZE(PS)) u_cc (
    .pclk(pclk), .rst(rst), .obstacle_x(cc_ox), .obstacle_y(cc_oy),
    .player_x(cc_px), .player_y(cc_py), .hit(cc_hit)
  );

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [3:0] prev_sel;

  task automatic step();
    @(posedge pclk);
    cyc++;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_dc(input string name, input int limit, output int n);
    n = 0;
    do begin
      prev_sel = bus.selected;
      step();
      n++;
    end while (bus.done_control !== 1'b1 && n < limit);
    chk(name, bus.done_control, 1);
  endtask

  task automatic wait_hit(input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (bus.player_hit !== 1'b1 && n < 20);
    chk(name, bus.player_hit, 1);
  endtask

  task automatic set_obs(input int x, input int y);
    bus.obstacle_x_in = coord_t'(x);
    bus.obstacle_y_in = coord_t'(y);
  endtask

  function automatic bit box_hit(input int px, input int py, input int ox, input int oy);
    return (ox != 0 || oy != 0) && ox >= px && ox <= px + PS - 1 &&
           oy >= py && oy <= py + PS - 1;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    cvec_t      cv[8];
    int         n, px, py, ox, oy, exp_lives, last_hit, stray, r;
    logic [3:0] exp_code, seen, prev_code;
    bit         hitq_m, c_new, running, exp_hit;

    cv[0] = '{400, 400, 410, 405, 1'b1};
    cv[1] = '{400, 400, 400, 400, 1'b1};
    cv[2] = '{400, 400, 419, 419, 1'b1};
    cv[3] = '{400, 400, 420, 405, 1'b0};
    cv[4] = '{400, 400, 410, 399, 1'b0};
    cv[5] = '{0,   0,   0,   0,   1'b0};
    cv[6] = '{4090, 4090, 4095, 4095, 1'b1};
    cv[7] = '{100, 100, 5,   5,   1'b0};

    bus.game_on = 0; bus.menu_on = 0; bus.play_selected = 0;
    bus.working_in = 0; bus.done_in = 0;
    set_obs(0, 0);
    bus.player_x = 12'd400; bus.player_y = 12'd400;
    cc_px = '0; cc_py = '0; cc_ox = '0; cc_oy = '0;

    repeat (2) step();
    chk("rst_selected", bus.selected, 0);
    chk("rst_done_control", bus.done_control, 0);
    chk("rst_player_hit", bus.player_hit, 0);
    chk("rst_lives", bus.lives, 0);
    chk("rst_game_over", bus.game_over, 0);
    rst = 0;

    foreach (cv[i]) begin
      cc_px = coord_t'(cv[i].px); cc_py = coord_t'(cv[i].py);
      cc_ox = coord_t'(cv[i].ox); cc_oy = coord_t'(cv[i].oy);
      step();
      chk($sformatf("coll_vec%0d", i), cc_hit, cv[i].hit);
    end

    // first start, then obstacles that never report working
    bus.game_on = 1; bus.play_selected = 1;
    wait_dc("first_start", 20, n);
`ifdef OBSTACLES_RANDOM_ORDER_EN
    chk("first_sel_onehot", $onehot(bus.selected) && prev_sel == bus.selected, 1);
`else
    chk("first_sel_before_start", prev_sel, 4'b0001);
    chk("first_sel_at_start", bus.selected, 4'b0001);
`endif
    chk("lives_loaded", bus.lives, LIVES);
    step();
    chk("start_pulse_width", bus.done_control, 0);

    exp_code  = 4'b0001;
    seen      = bus.selected;
    prev_code = bus.selected;
    for (int k = 0; k < NSEL; k++) begin
      wait_dc("sel_start", 200, n);
      chk("timeout_gap_cycles", n + ((k == 0) ? 1 : 0), TO + GAP + 2);
`ifdef OBSTACLES_RANDOM_ORDER_EN
      chk("rand_onehot", $onehot(bus.selected), 1);
      chk("rand_no_repeat", bus.selected != prev_code, 1);
      seen      = seen | bus.selected;
      prev_code = bus.selected;
`else
      exp_code = {exp_code[2:0], exp_code[3]};
      chk("rr_sel_before_start", prev_sel, exp_code);
      chk("rr_code", bus.selected, exp_code);
`endif
    end
`ifdef OBSTACLES_RANDOM_ORDER_EN
    chk("rand_all_codes", seen, 4'hF);
`endif

    // hit, cooldown, then spaced hits down to game over
    bus.working_in = 1;
    set_obs(410, 405);
    wait_hit("hit1");
    chk("lives_after_hit1", bus.lives, 2);
    stray = 0;
    repeat (100) begin
      step();
      if (bus.player_hit !== 1'b0) stray++;
    end
    chk("cooldown_ignores", stray, 0);
    chk("lives_held_cooldown", bus.lives, 2);
    for (int h = 0; h < 2; h++) begin
      set_obs(0, 0);
      repeat (HC) step();
      set_obs(410, 405);
      wait_hit("hit_spaced");
      chk("lives_spaced", bus.lives, 1 - h);
    end
    chk("game_over_set", bus.game_over, 1);
    chk("over_selected", bus.selected, 0);
    set_obs(0, 0);
    bus.play_selected = 0;
    repeat (5) step();
    chk("over_held", bus.game_over, 1);
    chk("over_lives", bus.lives, 0);
    bus.menu_on = 1;
    step();
    chk("over_exit", bus.game_over, 0);

    // abort from RUN via menu_on
    bus.menu_on = 0; bus.play_selected = 1;
    wait_dc("restart", 20, n);
    chk("restart_lives", bus.lives, LIVES);
    step(); step();
    bus.menu_on = 1;
    step();
    chk("abort_selected", bus.selected, 0);
    chk("abort_done_control", bus.done_control, 0);
    stray = 0;
    repeat (10) begin
      step();
      if (bus.done_control !== 1'b0 || bus.selected !== 4'b0) stray++;
    end
    chk("abort_idle_hold", stray, 0);
    chk("abort_lives_held", bus.lives, LIVES);

    // RUN ends on done_in, then on working_in falling
    bus.menu_on = 0;
    wait_dc("resume", 20, n);
    step();
    bus.done_in = 1;
    step();
    bus.done_in = 0;
    wait_dc("done_in_restart", 100, n);
    chk("done_in_gap_cycles", n, GAP + 2);
    step();
    bus.working_in = 0;
    step();
    wait_dc("drop_restart", 100, n);
    chk("working_drop_gap_cycles", n, GAP + 2);

    // synchronous reset wins over everything mid-RUN
    bus.working_in = 1;
    step();
    bus.done_in = 1; set_obs(410, 405);
    rst = 1;
    step();
    chk("midrun_rst_lives", bus.lives, 0);
    chk("midrun_rst_selected", bus.selected, 0);
    chk("midrun_rst_done_control", bus.done_control, 0);
    chk("midrun_rst_player_hit", bus.player_hit, 0);
    rst = 0; bus.done_in = 0; set_obs(0, 0);

    // randomized play: model counts a hit when the pixel one cycle earlier
    // collided and at least HC+1 cycles passed since the last counted hit
    last_hit = -100000;
    for (int g = 0; g < 3; g++) begin
      set_obs(0, 0);
      bus.menu_on = 1;
      step();
      bus.menu_on = 0;
      px = $urandom_range(4000, 10);
      py = $urandom_range(4000, 10);
      bus.player_x = coord_t'(px); bus.player_y = coord_t'(py);
      wait_dc("rand_start", 20, n);
      step(); step();
      exp_lives = LIVES; hitq_m = 0; running = 1;
      for (int t = 0; t < 3000 && running; t++) begin
        r = $urandom_range(9);
        if (r == 0) begin ox = 0; oy = 0; end
        else if (r == 1) begin ox = $urandom_range(4095, 1); oy = $urandom_range(4095, 1); end
        else begin ox = px - 3 + $urandom_range(25); oy = py - 3 + $urandom_range(25); end
        set_obs(ox, oy);
        c_new = box_hit(px, py, ox, oy);
        step();
        exp_hit = 0;
        if (running && hitq_m && (cyc - last_hit >= HC + 1)) begin
          exp_hit = 1;
          exp_lives--;
          last_hit = cyc;
          if (exp_lives == 0) running = 0;
        end
        hitq_m = c_new;
        chk("rand_player_hit", bus.player_hit, exp_hit);
        chk("rand_lives", bus.lives, exp_lives);
        chk("rand_game_over", bus.game_over, (exp_lives == 0) ? 1 : 0);
      end
      chk("rand_game_end", running, 0);
      chk("rand_over_selected", bus.selected, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
